sym_source_upsampler: RTL and testbench
=======================================

Name: sym_source_upsampler

Overview:
Baseband test-signal source for the 4-ASK transmit chain. It sits directly downstream of the clock-enable generator and consumes its symbol-rate and sample-rate strobes. On each symbol strobe it emits a preamble or PRBS-15 symbol, mapped to a Gray-coded 4-level signed sample. On each sample strobe it emits that level zero-stuffed to SPS samples/symbol, which feeds the pulse-shaping filter.

Parameters:
OUT_W, 18, sample width, signed 1s17
SPS, 4, samples per symbol (sam strobes per sym strobe)
LEVEL_A, 8192, inner amplitude A (0.0625); outer = 3A = 24576
PREAMBLE_LEN, 8, preamble symbols per burst
LFSR_SEED, 15'h0001, PRBS reload value (non-zero)

Ports:
clk  in  1  system clock; strobes are single-cycle pulses in this domain
reset  in  1  synchronous, active-high
sym_clk_en  in  1  symbol-rate strobe; coincides with every SPS-th sam_clk_en
sam_clk_en  in  1  sample-rate strobe
start  in  1  begin burst (pulse, honoured only in IDLE)
burst_len  in  16  payload symbols; 0 = continuous
sample_out  out  OUT_W  signed upsampled sample
sample_valid  out  1  1-cycle pulse per sam_clk_en
symbol_out  out  2  current symbol bits
symbol_valid  out  1  1-cycle pulse per emitted symbol
busy  out  1  burst in progress
done  out  1  1-cycle pulse, burst complete
align_err  out  1  sticky strobe-alignment error

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: all outputs 0. FSM=IDLE. LFSR=LFSR_SEED. Phase counter 0.
- FSM states: IDLE, WAIT_SYM, PREAMBLE, PAYLOAD.
- IDLE: start -> WAIT_SYM. Latch burst_len. Reload LFSR. Clear align_err. A sym_clk_en in the same cycle as start is not used.
- WAIT_SYM: next sym_clk_en -> PREAMBLE and emits preamble symbol 0.
- PREAMBLE: symbols alternate 10, 00 (+3A, -3A), starting with 10. After PREAMBLE_LEN symbols the next sym_clk_en emits payload symbol 1 and enters PAYLOAD.
- PAYLOAD: each sym_clk_en advances the LFSR two steps.
  - Step: nb = l[14]^l[13]; l <= {l[13:0], nb}.
  - symbol = {nb_step1, nb_step2}.
  - If the LFSR is ever all-zero, reload LFSR_SEED.
- Burst end: the final symbol (count == latched burst_len, non-zero) asserts done in the same cycle as its symbol_valid, then returns to IDLE. burst_len=0 never ends; only reset stops it.
- busy = 1 in WAIT_SYM/PREAMBLE/PAYLOAD. It drops in the cycle done asserts.
- start while busy is ignored.
- Gray map: 00 -> -3A, 01 -> -A, 11 -> +A, 10 -> +3A.
- Latency: symbol_out/symbol_valid update 1 clk after the sym_clk_en edge. sample_out/sample_valid update 1 clk after the sam_clk_en edge.
- Upsampling:
  - A sam_clk_en coincident with sym_clk_en outputs the new symbol's level and sets phase = 1.
  - Other sam_clk_en output 0 and increment phase.
  - sample_out holds between strobes.
- Outside PREAMBLE/PAYLOAD, every sam_clk_en still pulses sample_valid with sample_out=0, so the downstream filter keeps flushing.
- The sample carrying the final symbol is emitted. Its zero-stuff samples follow in IDLE.
- align_err (sticky, cleared by reset or accepted start) sets on either condition:
  - sym_clk_en without sam_clk_en (still emits the symbol sample);
  - phase reaching SPS without sym_clk_en (still emits 0; phase saturates).
- Reset mid-burst: immediate return to reset values. No done pulse.

Decomposition:
- Package sym_src_pkg:
  - state enum;
  - Gray map function;
  - LEVEL_A/3A constants;
  - PRBS tap indices (14, 13);
  - default seed.
- One sub-module: prbs15_lfsr. Two-step advance per enable, seed load, zero-lockup guard, 2-bit output.

Test Plan:
- Reset, then 64 strobe periods without start -> sample_valid every 4th sys strobe, sample_out=0, busy=0, symbol_valid never.
- start with burst_len=10 -> preamble sample_out sequence +24576,0,0,0,-24576,0,0,0 for 8 symbols.
- Payload symbols 1-6 = 00 (-24576); symbol 7 = 01 (-8192).
- Same burst -> done pulses with the 10th payload symbol_valid; busy falls that cycle; the next sam strobes output 0.
- burst_len=0 -> payload runs >32767 symbols with no done. The PRBS sequence repeats with period 32767 bit-pairs; check against a reference model.
- Assert reset during PAYLOAD symbol 3 -> all outputs 0 next cycle. A new start restarts from preamble symbol 10 and seed 0x0001.
- Suppress one sam_clk_en under a sym_clk_en -> align_err=1, symbol sample still emitted. Then inject 5 sam strobes between syms -> align_err stays 1 and the extra sample is 0. Next accepted start clears align_err.

Source files
------------

// File: rtl/sym_src_pkg.sv
// sym_src_pkg: shared state encoding, Gray level map and PRBS-15 constants.
package sym_src_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_SYM, PREAMBLE, PAYLOAD} state_t;
    localparam int LEVEL_A_DEF = 8192;
    localparam int LEVEL_3A_DEF = 3 * LEVEL_A_DEF;
    localparam int TAP_HI = 14;
    localparam int TAP_LO = 13;
    localparam logic [14:0] SEED_DEF = 15'h0001;
    function automatic int gray_level(input logic [1:0] s, input int a);
        return s[1] ? (s[0] ? a : 3 * a) : (s[0] ? -a : -3 * a);
    endfunction
endpackage

// File: rtl/prbs15_lfsr.sv
// prbs15_lfsr: PRBS-15 generator advancing two steps per enable, yielding a 2-bit symbol.
module prbs15_lfsr
    import sym_src_pkg::*;
#(
    parameter logic [14:0] SEED = SEED_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       adv_i,
    output logic [1:0] sym_o
);
    logic [14:0] l_q, l0, l1, l2;
    // An all-zero register would lock up, so it is treated as the seed.
    assign l0 = l_q == '0 ? SEED : l_q;
    assign l1 = {l0[13:0], l0[TAP_HI] ^ l0[TAP_LO]};
    assign l2 = {l1[13:0], l1[TAP_HI] ^ l1[TAP_LO]};
    assign sym_o = {l1[0], l2[0]};
    always_ff @(posedge clk) begin
        if (reset || load_i) l_q <= SEED;
        else if (adv_i) l_q <= l2;
        else if (l_q == '0) l_q <= SEED;
    end
endmodule

// File: rtl/sym_source_upsampler.sv
// sym_source_upsampler: preamble/PRBS 4-ASK symbol source, zero-stuffed to SPS samples per symbol.
module sym_source_upsampler
    import sym_src_pkg::*;
#(
    parameter int          OUT_W        = 18,
    parameter int          SPS          = 4,
    parameter int          LEVEL_A      = LEVEL_A_DEF,
    parameter int          PREAMBLE_LEN = 8,
    parameter logic [14:0] LFSR_SEED    = SEED_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_clk_en,
    input  logic             sam_clk_en,
    input  logic             start,
    input  logic [15:0]      burst_len,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    output logic [1:0]       symbol_out,
    output logic             symbol_valid,
    output logic             busy,
    output logic             done,
    output logic             align_err
);
    localparam int PW = $clog2(SPS + 1);
    state_t state_q, state_d;
    logic [15:0] len_q, cnt_q, cnt_d;
    logic [PW-1:0] phase_q;
    logic [1:0] prbs_sym, sym_d;
    logic emit, adv, load, fin, pre_last;

    assign load = state_q == IDLE && start;
    assign emit = sym_clk_en && state_q != IDLE;
    assign pre_last = state_q == PREAMBLE && cnt_q == 16'(PREAMBLE_LEN);
    assign adv = sym_clk_en && (state_q == PAYLOAD || pre_last);
    assign cnt_d = state_q == WAIT_SYM || pre_last ? 16'd1 : cnt_q + 16'd1;
    assign fin = adv && len_q != '0 && cnt_d == len_q;
    // Preamble alternates +3A/-3A starting with +3A; cnt_q is the index of the next preamble symbol.
    assign sym_d = state_q == WAIT_SYM ? 2'b10 :
                   state_q == PREAMBLE && !pre_last ? (cnt_q[0] ? 2'b00 : 2'b10) : prbs_sym;
    assign state_d = fin ? IDLE :
                     state_q == IDLE ? (start ? WAIT_SYM : IDLE) :
                     !sym_clk_en ? state_q :
                     state_q == WAIT_SYM ? PREAMBLE :
                     adv ? PAYLOAD : state_q;

    prbs15_lfsr #(.SEED(LFSR_SEED)) u_prbs (
        .clk(clk),
        .reset(reset),
        .load_i(load),
        .adv_i(adv),
        .sym_o(prbs_sym)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q <= '0;
            cnt_q <= '0;
            phase_q <= '0;
            sample_out <= '0;
            sample_valid <= 1'b0;
            symbol_out <= '0;
            symbol_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state_q <= state_d;
            busy <= state_d != IDLE;
            done <= fin;
            sample_valid <= sam_clk_en | sym_clk_en;
            symbol_valid <= emit;
            if (load) len_q <= burst_len;
            if (emit) begin
                symbol_out <= sym_d;
                cnt_q <= cnt_d;
            end
            if (sam_clk_en | sym_clk_en) sample_out <= emit ? OUT_W'(gray_level(sym_d, LEVEL_A)) : '0;
            phase_q <= sym_clk_en ? PW'(1) :
                       sam_clk_en && phase_q != PW'(SPS) ? phase_q + 1'b1 : phase_q;
            // A set in the same cycle as an accepted start wins over the clear.
            align_err <= (align_err && !load) || (sym_clk_en && !sam_clk_en) ||
                         (sam_clk_en && !sym_clk_en && phase_q == PW'(SPS));
        end
    end
endmodule

// File: tb/tb_sym_source_upsampler.sv
// tb_sym_source_upsampler: randomized strobe stimulus checked cycle by cycle against a sequence-level model.
module tb_sym_source_upsampler;
    localparam int PRE = 8;
    localparam int SPS = 4;
    localparam int NCONT = 32800;
    logic clk = 1'b0;
    logic reset, sym_clk_en, sam_clk_en, start;
    logic [15:0] burst_len;
    logic [17:0] sample_out;
    logic sample_valid, symbol_valid, busy, done, align_err;
    logic [1:0] symbol_out;
    int total = 0, bad = 0;
    bit prbs [0:65999];
    int mode = 0, n = 0, ph = 0, m_len = 0, e_smp = 0;
    bit m_err = 0, e_smpv = 0, e_symv = 0, e_dn = 0;
    logic [1:0] m_sym = '0;

    always #5 clk = ~clk;

    sym_source_upsampler dut (
        .clk(clk),
        .reset(reset),
        .sym_clk_en(sym_clk_en),
        .sam_clk_en(sam_clk_en),
        .start(start),
        .burst_len(burst_len),
        .sample_out(sample_out),
        .sample_valid(sample_valid),
        .symbol_out(symbol_out),
        .symbol_valid(symbol_valid),
        .busy(busy),
        .done(done),
        .align_err(align_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, $signed(got), $signed(exp), $time);
        end
    endtask

    function automatic int lvl(input logic [1:0] s);
        case (s)
            2'b00: return -24576;
            2'b01: return -8192;
            2'b11: return 8192;
            default: return 24576;
        endcase
    endfunction

    // One clock: drive inputs, advance the model by the spec rules, then compare after the edge.
    task automatic cyc(input bit st, input bit sm, input bit sy, input logic [15:0] bl, input bit rs);
        bit emitted, was_idle;
        logic [1:0] s;
        start = st;
        sam_clk_en = sm;
        sym_clk_en = sy;
        burst_len = bl;
        reset = rs;
        emitted = 0;
        s = m_sym;
        was_idle = mode == 0;
        e_dn = 0;
        e_symv = 0;
        e_smpv = sm | sy;
        if (rs) begin
            mode = 0; n = 0; ph = 0; m_err = 0; m_sym = '0; e_smp = 0; e_smpv = 0; m_len = 0;
        end else begin
            if (sy && mode != 0) begin
                s = n < PRE ? (n % 2 == 0 ? 2'b10 : 2'b00) :
                    {prbs[15 + 2 * (n - PRE)], prbs[16 + 2 * (n - PRE)]};
                n++;
                emitted = 1;
                e_symv = 1;
                m_sym = s;
                mode = 2;
                if (m_len != 0 && n == PRE + m_len) begin
                    e_dn = 1;
                    mode = 0;
                end
            end
            if (sm | sy) e_smp = emitted ? lvl(s) : 0;
            if (st && was_idle) begin
                mode = 1; m_len = int'(bl); n = 0; m_err = 0;
            end
            if (sy) begin
                if (!sm) m_err = 1;
                ph = 1;
            end else if (sm) begin
                if (ph == SPS) m_err = 1;
                else ph++;
            end
        end
        @(posedge clk);
        #1;
        check_eq("sample_valid", 32'(sample_valid), 32'(e_smpv));
        check_eq("sample_out", 32'($signed(sample_out)), e_smp);
        check_eq("symbol_valid", 32'(symbol_valid), 32'(e_symv));
        check_eq("symbol_out", 32'(symbol_out), 32'(m_sym));
        check_eq("busy", 32'(busy), 32'(mode != 0));
        check_eq("done", 32'(done), 32'(e_dn));
        check_eq("align_err", 32'(align_err), 32'(m_err));
    endtask

    // One symbol period: sym on the first of nsam sample strobes, gap idle cycles after each.
    task automatic period(input bit sy, input bit sym_sam, input int nsam, input int gap,
                          input bit st_rand, input logic [15:0] bl);
        for (int k = 0; k < nsam; k++) begin
            cyc(0, (k > 0) || sym_sam, sy && (k == 0), bl, 0);
            for (int g = 0; g < gap; g++) cyc(st_rand && $urandom_range(0, 15) == 0, 0, 0, bl, 0);
        end
    endtask

    initial begin
        // x^15 + x^14 + 1 as a bit recurrence; entries 0..14 hold the seed history.
        for (int j = 0; j < 15; j++) prbs[j] = (j == 14);
        for (int t = 0; t + 15 < 66000; t++) prbs[t + 15] = prbs[t] ^ prbs[t + 1];
        repeat (3) cyc(0, 0, 0, 16'd0, 1);
        repeat (64) period(1, 1, SPS, 1, 0, 16'd0);
        cyc(1, 0, 0, 16'd10, 0);
        repeat (22) period(1, 1, SPS, 1, 0, 16'd10);
        repeat (120) period(1, 1, SPS, $urandom_range(0, 3), 1, 16'($urandom_range(1, 20)));
        cyc(0, 0, 0, 16'd0, 1);
        cyc(1, 0, 0, 16'd0, 0);
        repeat (11) period(1, 1, SPS, 1, 0, 16'd0);
        cyc(0, 0, 0, 16'd0, 1);
        cyc(1, 0, 0, 16'd12, 0);
        repeat (24) period(1, 1, SPS, 1, 0, 16'd12);
        cyc(1, 0, 0, 16'd6, 0);
        repeat (2) period(1, 1, SPS, 1, 0, 16'd6);
        period(1, 0, SPS, 1, 0, 16'd6);
        period(1, 1, SPS + 2, 1, 0, 16'd6);
        repeat (12) period(1, 1, SPS, 1, 0, 16'd6);
        cyc(1, 0, 0, 16'd3, 0);
        repeat (14) period(1, 1, SPS, 1, 0, 16'd3);
        cyc(1, 0, 0, 16'd0, 0);
        repeat (PRE + NCONT) cyc(0, 1, 1, 16'd0, 0);
        cyc(0, 0, 0, 16'd0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
